frame_scanner: RTL

FRAME_SCANNER -- requirements
Module: frame_scanner

---
 rtl/frame_scanner_pkg.sv | 19 +
 rtl/scan_delay_line.sv | 38 +++
 rtl/frame_scanner.sv | 126 ++++++++++++
 3 files changed

// File: rtl/frame_scanner_pkg.sv
// Shared DinoGame constants: screen geometry, color width and the scan tap payload.
package frame_scanner_pkg;

    localparam int unsigned SCREEN_W_DEF = 160;
    localparam int unsigned SCREEN_H_DEF = 120;
    localparam int unsigned COLOR_W      = 3;
    localparam int unsigned COORD_W      = 8;
    localparam int unsigned OVERRUN_W    = 8;

    // One issued pixel travelling through the renderer-latency delay line.
    typedef struct packed {
        logic               valid;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } scan_tap_t;

    localparam int unsigned TAP_W = $bits(scan_tap_t);

endpackage

// File: rtl/scan_delay_line.sv
// Fixed-depth shift register that aligns issued coordinates with renderer output.
module scan_delay_line
    import frame_scanner_pkg::*;
#(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = TAP_W
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stages;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    stages <= '0;
                end else begin
                    stages[0] <= din;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    stages <= '0;
                end else begin
                    stages <= {stages[DEPTH-2:0], din};
                end
            end
        end
    endgenerate

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/frame_scanner.sv
// Walks the screen once per frame tick, feeding x/y to the renderer and
// forwarding renderer colors to the VGA adapter after RENDER_LAT cycles.
module frame_scanner
    import frame_scanner_pkg::*;
#(
    parameter int unsigned SCREEN_W   = SCREEN_W_DEF,
    parameter int unsigned SCREEN_H   = SCREEN_H_DEF,
    parameter int unsigned RENDER_LAT = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 frameClk,
    output logic [COORD_W-1:0]   x,
    output logic [COORD_W-1:0]   y,
    input  logic [COLOR_W-1:0]   color,
    output logic                 plot,
    output logic [COORD_W-1:0]   vgaX,
    output logic [COORD_W-1:0]   vgaY,
    output logic [COLOR_W-1:0]   vgaColor,
    output logic                 busy,
    output logic                 frameDone,
    output logic [OVERRUN_W-1:0] overrunCount
);

    localparam logic [COORD_W-1:0]   X_LAST      = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0]   Y_LAST      = COORD_W'(SCREEN_H - 1);
    localparam int unsigned          DRAIN_W     = 3;
    localparam logic [DRAIN_W-1:0]   DRAIN_LAST  = DRAIN_W'(RENDER_LAT - 1);
    localparam logic [OVERRUN_W-1:0] OVERRUN_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    state_t             state;
    logic               frame_clk_prev;
    logic               frame_edge;
    logic [DRAIN_W-1:0] drain_cnt;
    scan_tap_t          tap_in;
    scan_tap_t          tap_out;

    assign frame_edge = frameClk & ~frame_clk_prev;

    // Scan sequencer; prev resets high so a tick held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= IDLE;
            frame_clk_prev <= 1'b1;
            x              <= '0;
            y              <= '0;
            busy           <= 1'b0;
            frameDone      <= 1'b0;
            drain_cnt      <= '0;
            overrunCount   <= '0;
        end else begin
            frame_clk_prev <= frameClk;
            frameDone      <= 1'b0;

            if (frame_edge && (state != IDLE) && (overrunCount != OVERRUN_MAX)) begin
                overrunCount <= overrunCount + OVERRUN_W'(1);
            end

            case (state)
                IDLE: begin
                    if (frame_edge) begin
                        state <= SCAN;
                        x     <= '0;
                        y     <= '0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if ((x == X_LAST) && (y == Y_LAST)) begin
                        state     <= DRAIN;
                        drain_cnt <= '0;
                    end else if (x == X_LAST) begin
                        x <= '0;
                        y <= y + COORD_W'(1);
                    end else begin
                        x <= x + COORD_W'(1);
                    end
                end
                DRAIN: begin
                    // Last issued pixel leaves the delay line during the final DRAIN cycle.
                    if (drain_cnt == DRAIN_LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        frameDone <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRAIN_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign tap_in.valid = (state == SCAN);
    assign tap_in.x     = x;
    assign tap_in.y     = y;

    scan_delay_line #(
        .DEPTH (RENDER_LAT),
        .WIDTH (TAP_W)
    ) u_delay (
        .clk    (clk),
        .resetn (resetn),
        .din    (tap_in),
        .dout   (tap_out)
    );

    assign plot     = tap_out.valid;
    assign vgaX     = tap_out.x;
    assign vgaY     = tap_out.y;
    // Renderer color is only meaningful on plot cycles.
    assign vgaColor = tap_out.valid ? color : '0;

endmodule
